// File: rtl/cmd_pkg.sv
// cmd_pkg: command word layout shared by the SPI receiver, the brain FSM and host tooling
package cmd_pkg;
    localparam int CMD_WORD_W = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int VMASK_MSB  = 27;
    localparam int VMASK_LSB  = 20;
    typedef enum logic [3:0] {NOP = 4'd0, SET_CMD = 4'd1, TOGGLE_VC = 4'd2} cmd_op_e;
    typedef enum logic [1:0] {IDLE, RX, PUSH} rx_state_e;
    function automatic logic [3:0] cmd_opcode(input logic [CMD_WORD_W-1:0] w);
        return w[OPCODE_MSB:OPCODE_LSB];
    endfunction
    function automatic logic [7:0] cmd_vmask(input logic [CMD_WORD_W-1:0] w);
        return w[VMASK_MSB:VMASK_LSB];
    endfunction
endpackage

// File: rtl/spi_cmd_rx_if.sv
// spi_cmd_rx_if: show-ahead command stream from the receiver FIFO to its consumer
interface spi_cmd_rx_if
    import cmd_pkg::*;
#(
    parameter int W = CMD_WORD_W
);
    logic [W-1:0] cmd_data;
    logic         cmd_data_valid;
    logic         cmd_data_read;
    modport master (output cmd_data, cmd_data_valid, input cmd_data_read);
    modport slave (input cmd_data, cmd_data_valid, output cmd_data_read);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with a registered head word and separate occupancy count
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
    // rdata tracks the head: bypass the write when the FIFO is (or becomes) empty of older words
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
            rdata  <= (empty || (do_pop && level == (AW+1)'(1))) ? (do_push ? wdata : rdata)
                    : do_pop ? mem[rd_ptr + AW'(1)] : rdata;
        end
    end
endmodule

// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx: oversampled SPI mode-0 slave collecting 32-bit command words into a show-ahead FIFO
module spi_cmd_rx
    import cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int WORD_BITS = CMD_WORD_W,
    parameter int SYNC_STAGES = 2,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk147,
    input  logic          rst,
    input  logic          spi_sclk,
    input  logic          spi_mosi,
    input  logic          spi_cs_n,
    spi_cmd_rx_if.master  cmd,
    output logic [LW-1:0] fifo_level,
    output logic          overflow,
    output logic          frame_err,
    input  logic          err_clr
);
    localparam int CW = $clog2(WORD_BITS);
    logic [SYNC_STAGES-1:0] sclk_s, mosi_s, cs_s;
    logic                   sclk_p, cs_p;
    logic                   sclk_rise, cs_fall, cs_rise, push, full, empty;
    logic [CW-1:0]          bit_cnt;
    logic [WORD_BITS-1:0]   shreg;
    rx_state_e              state;
    // cs history resets low so a frame already in progress at reset release is never picked up
    always_ff @(posedge clk147) begin
        if (rst) begin
            sclk_s <= '0;
            mosi_s <= '0;
            cs_s   <= '0;
            sclk_p <= 1'b0;
            cs_p   <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi_sclk};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], spi_cs_n};
            sclk_p <= sclk_s[SYNC_STAGES-1];
            cs_p   <= cs_s[SYNC_STAGES-1];
        end
    end
    assign sclk_rise = sclk_s[SYNC_STAGES-1] && !sclk_p;
    assign cs_fall   = !cs_s[SYNC_STAGES-1] && cs_p;
    assign cs_rise   = cs_s[SYNC_STAGES-1] && !cs_p;
    assign push      = state == PUSH;
    always_ff @(posedge clk147) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (push && full && !cmd.cmd_data_read) || (overflow && !err_clr);
            frame_err <= (state == RX && cs_rise && bit_cnt != '0) || (frame_err && !err_clr);
            case (state)
                IDLE: if (cs_fall) begin
                    bit_cnt <= '0;
                    state   <= RX;
                end
                RX: if (cs_rise) state <= IDLE;
                else if (sclk_rise) begin
                    shreg   <= {shreg[WORD_BITS-2:0], mosi_s[SYNC_STAGES-1]};
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(WORD_BITS - 1)) state <= PUSH;
                end
                PUSH: begin
                    bit_cnt <= '0;
                    state   <= cs_s[SYNC_STAGES-1] ? IDLE : RX;
                end
                default: state <= IDLE;
            endcase
        end
    end
    sync_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_BITS)) u_fifo (
        .clk   (clk147),
        .rst   (rst),
        .push  (push),
        .pop   (cmd.cmd_data_read),
        .wdata (shreg),
        .rdata (cmd.cmd_data),
        .empty (empty),
        .full  (full),
        .level (fifo_level)
    );
    assign cmd.cmd_data_valid = !empty;
endmodule

// File: tb/tb_spi_cmd_rx.sv
// tb_spi_cmd_rx: bit-banged SPI host with a scoreboard of expected words checked on every pop
module tb_spi_cmd_rx;
    localparam int H = 8;
    logic        clk147 = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        err_clr = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow, frame_err;
    logic [31:0] q[$];
    logic [31:0] w;
    int          n_chk = 0;
    int          n_pass = 0;
    spi_cmd_rx_if #(.W(32)) cmd ();
    spi_cmd_rx #(.FIFO_DEPTH(16), .WORD_BITS(32), .SYNC_STAGES(2)) dut (
        .clk147     (clk147),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .cmd        (cmd),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );
    always #5 clk147 = ~clk147;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk147);
            #2;
        end
    endtask
    task automatic shift_bits(input logic [31:0] d, input int n);
        for (int i = 31; i > 31 - n; i--) begin
            spi_mosi = d[i];
            spi_sclk = 1'b0;
            tick(H);
            spi_sclk = 1'b1;
            tick(H);
        end
        spi_sclk = 1'b0;
        tick(H);
    endtask
    task automatic cs_low();
        spi_cs_n = 1'b0;
        tick(H);
    endtask
    task automatic cs_high();
        spi_cs_n = 1'b1;
        tick(H);
    endtask
    task automatic send_word(input logic [31:0] d);
        shift_bits(d, 32);
        if (q.size() < 16) q.push_back(d);
    endtask
    task automatic drain(input int n);
        cmd.cmd_data_read = 1'b1;
        tick(n);
        cmd.cmd_data_read = 1'b0;
        tick(1);
    endtask
    always @(negedge clk147) begin : mon
        logic [31:0] e;
        if (!rst && cmd.cmd_data_valid && cmd.cmd_data_read) begin
            e = 'x;
            if (q.size() > 0) e = q.pop_front();
            check("pop", cmd.cmd_data, e);
        end
    end
    initial begin
        cmd.cmd_data_read = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);
        check("rst_data", cmd.cmd_data, 32'h0);
        check("rst_valid", cmd.cmd_data_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        // single word, latency measured from the 32nd sclk rise
        w = 32'h1A50_0000;
        cs_low();
        shift_bits(w, 31);
        spi_mosi = w[0];
        tick(H);
        spi_sclk = 1'b1;
        tick(3);
        check("lat_valid_early", cmd.cmd_data_valid, 0);
        tick(1);
        check("lat_valid", cmd.cmd_data_valid, 1);
        check("lat_data", cmd.cmd_data, w);
        q.push_back(w);
        tick(H - 4);
        spi_sclk = 1'b0;
        tick(H);
        cs_high();
        check("one_level", fifo_level, 1);
        check("one_ferr", frame_err, 0);
        drain(2);
        check("one_empty", cmd.cmd_data_valid, 0);
        // three words in one frame, then consecutive pops
        cs_low();
        send_word(32'h1000_0001);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0005);
        cs_high();
        check("three_level", fifo_level, 3);
        check("three_head", cmd.cmd_data, 32'h1000_0001);
        cmd.cmd_data_read = 1'b1;
        tick(1);
        check("pop_level2", fifo_level, 2);
        tick(1);
        check("pop_level1", fifo_level, 1);
        tick(1);
        check("pop_level0", fifo_level, 0);
        check("pop_valid0", cmd.cmd_data_valid, 0);
        cmd.cmd_data_read = 1'b0;
        tick(2);
        // 17 words into a 16-deep FIFO
        cs_low();
        for (int i = 0; i < 17; i++) send_word(32'hA000_0000 + 32'(i * 3));
        cs_high();
        check("ovf_level", fifo_level, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_head", cmd.cmd_data, 32'hA000_0000);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        // word completes in the same cycle as a pop while full
        w = 32'h5A5A_1234;
        cs_low();
        shift_bits(w, 31);
        spi_mosi = w[0];
        tick(H);
        spi_sclk = 1'b1;
        tick(3);
        cmd.cmd_data_read = 1'b1;
        tick(1);
        cmd.cmd_data_read = 1'b0;
        q.push_back(w);
        check("fullpop_level", fifo_level, 16);
        check("fullpop_ovf", overflow, 0);
        tick(H - 4);
        spi_sclk = 1'b0;
        tick(H);
        cs_high();
        drain(20);
        check("drain_level", fifo_level, 0);
        check("drain_sb", q.size(), 0);
        // cs_n rises after 12 bits
        cs_low();
        shift_bits(32'hFFF0_0000, 12);
        cs_high();
        check("ferr_flag", frame_err, 1);
        check("ferr_level", fifo_level, 0);
        cs_low();
        send_word(32'hCAFE_F00D);
        cs_high();
        check("ferr_next_level", fifo_level, 1);
        check("ferr_next_data", cmd.cmd_data, 32'hCAFE_F00D);
        check("ferr_sticky", frame_err, 1);
        drain(2);
        // reset mid-word with four words queued
        cs_low();
        for (int i = 0; i < 4; i++) send_word(32'h0BAD_0000 + 32'(i));
        cs_high();
        check("prerst_level", fifo_level, 4);
        w = 32'h7654_3210;
        cs_low();
        shift_bits(w, 20);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        q.delete();
        tick(1);
        check("midrst_level", fifo_level, 0);
        check("midrst_valid", cmd.cmd_data_valid, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_ferr", frame_err, 0);
        shift_bits(w << 20, 12);
        cs_high();
        check("tail_level", fifo_level, 0);
        check("tail_ferr", frame_err, 0);
        cs_low();
        send_word(32'h1234_5678);
        cs_high();
        check("after_level", fifo_level, 1);
        drain(2);
        check("after_sb", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
